// File: rtl/err_pkg.sv
// Shared types and constants for the line-follower error computation path.
package err_pkg;

    // Sequencer states: idle, clear accumulator, accumulate terms, result ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } err_state_t;

    // Width of the datapath operand-mux select
    localparam int SEL_W  = 3;

    // Number of IR readings (four right, four left)
    localparam int NUM_IR = 8;

endpackage : err_pkg

// File: rtl/err_compute_sm.sv
// Control sequencer for err_compute_DP: clears the error register on a new
// set of IR readings, walks the operand mux across all weighted readings
// (even sel = right reading, added; odd sel = left reading, subtracted) and
// pulses err_vld once the sum is final. One request may be buffered while a
// computation is in flight; further requests during that time are dropped.
module err_compute_sm
    import err_pkg::*;
#(
    // Accumulate cycles per computation; even, 2..NUM_IR
    parameter int NUM_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IR_vld,
    output logic             clr_accum,
    output logic             en_accum,
    output logic             sub,
    output logic [SEL_W-1:0] sel,
    output logic             err_vld,
    output logic             busy
);

    // Counter value on the last accumulate cycle
    localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(NUM_TERMS - 1);

    err_state_t       state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;

    // Next-state, counter and request-buffer logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (IR_vld) state_d = CLR;
            end
            CLR: begin
                state_d = ACCUM;
                cnt_d   = '0;
                if (IR_vld) pending_d = 1'b1;
            end
            ACCUM: begin
                if (IR_vld) pending_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // A request arriving right now is served directly and never
                // touches the buffer; the buffer empties on this exit edge.
                state_d   = (pending_q || IR_vld) ? CLR : IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // State registers plus outputs registered from the next state, so the
    // outputs are a pure function of the current state/count each cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            clr_accum <= 1'b0;
            en_accum  <= 1'b0;
            sub       <= 1'b0;
            sel       <= '0;
            err_vld   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            clr_accum <= (state_d == CLR);
            en_accum  <= (state_d == ACCUM);
            sel       <= (state_d == ACCUM) ? cnt_d : '0;
            sub       <= (state_d == ACCUM) && cnt_d[0];
            err_vld   <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule : err_compute_sm

// File: tb/tb_err_compute_sm.sv
// Self-checking bench for err_compute_sm: a vector table, hand sequences for
// the multi-cycle corners (with a behavioural error datapath), and random
// traffic checked against a schedule model of request start times.
module tb_err_compute_sm;
    import err_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, IR_vld;

    logic       clr8, en8, sub8, err8, busy8;
    logic [2:0] sel8;
    logic       clr4, en4, sub4, err4, busy4;
    logic [2:0] sel4;

    err_compute_sm #(.NUM_TERMS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld),
        .clr_accum(clr8), .en_accum(en8), .sub(sub8), .sel(sel8),
        .err_vld(err8), .busy(busy8));

    err_compute_sm #(.NUM_TERMS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld),
        .clr_accum(clr4), .en_accum(en4), .sub(sub4), .sel(sel4),
        .err_vld(err4), .busy(busy4));

    logic [7:0] v8, v4;
    assign v8 = {clr8, en8, sub8, sel8, err8, busy8};
    assign v4 = {clr4, en4, sub4, sel4, err4, busy4};

    // Behavioural error datapath driven by the 8-term sequencer
    logic [11:0] R [4];
    logic [11:0] L [4];
    logic [15:0] acc, op;
    always_comb op = {4'b0, (sel8[0] ? L[sel8[2:1]] : R[sel8[2:1]])} << sel8[2:1];
    always @(posedge clk) begin
        if (clr8)     acc <= 16'h0;
        else if (en8) acc <= sub8 ? acc - op : acc + op;
    end

    int checks = 0;
    int failures = 0;
    int e = -1;  // index of the most recent clock edge

    // Schedule model: each computation occupies NT+2 consecutive cycles
    // starting at its clear cycle; only the latest and previous starts matter.
    int last_s [2];
    int prev_s [2];

    function automatic int nt_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic logic [7:0] pk(input bit c, input bit en, input bit s,
                                      input int sl, input bit er, input bit b);
        return {c, en, s, 3'(sl), er, b};
    endfunction

    function automatic logic [7:0] mexp(input int k, input int t);
        int nt, o;
        nt = nt_of(k);
        o = t - last_s[k];
        if (o < 0 || o > nt + 1) o = t - prev_s[k];
        if (o < 0 || o > nt + 1) return 8'h00;
        if (o == 0)      return pk(1, 0, 0, 0, 0, 1);
        if (o <= nt)     return pk(0, 1, bit'((o - 1) & 1), o - 1, 0, 1);
        return pk(0, 0, 0, 0, 1, 1);
    endfunction

    task automatic model_edge(input int k, input bit r, input bit i);
        int nt;
        nt = nt_of(k);
        if (!r) begin
            last_s[k] = -1000;
            prev_s[k] = -1000;
        end else if (i) begin
            if (last_s[k] > e - 1) begin
                // a request is already waiting: this one is dropped
            end else if (e - 1 >= last_s[k] + nt + 1) begin
                prev_s[k] = last_s[k];
                last_s[k] = e;
            end else begin
                prev_s[k] = last_s[k];
                last_s[k] = last_s[k] + nt + 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, e, got, exp);
        end
    endtask

    // Apply inputs for one edge, advance the model, compare both DUTs
    task automatic tick(input bit r, input bit i);
        rst_n  = r;
        IR_vld = i;
        @(posedge clk);
        e++;
        model_edge(0, r, i);
        model_edge(1, r, i);
        #1;
        chk("model8", 16'(v8), 16'(mexp(0, e)));
        chk("model4", 16'(v4), 16'(mexp(1, e)));
        chk("excl8", 16'(((clr8 & en8) | (err8 & en8)) ? 1 : 0), 16'h0);
        chk("excl4", 16'(((clr4 & en4) | (err4 & en4)) ? 1 : 0), 16'h0);
    endtask

    task automatic idle_out(input int n);
        for (int j = 0; j < n; j++) tick(1, 0);
    endtask

    // One integrated computation: load readings, pulse, check error at err_vld
    task automatic run_dp(input string name, input logic [15:0] expv);
        bit seen;
        seen = 0;
        tick(1, 1);
        for (int j = 0; j < 20 && !seen; j++) begin
            tick(1, 0);
            if (err8) begin
                seen = 1;
                chk(name, acc, expv);
            end
        end
        if (!seen) chk({name, "_timeout"}, 16'h0, 16'h1);
        idle_out(3);
    endtask

    typedef struct {
        bit         r;
        bit         i;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int s;
        int errs [$];
        int cnt4;
        bit saw_en;
        rst_n  = 1'b0;
        IR_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin last_s[k] = -1000; prev_s[k] = -1000; end
        for (int j = 0; j < 4; j++) begin R[j] = '0; L[j] = '0; end

        // Vector table: reset with IR_vld held high, release, single request
        tbl[0]  = '{0, 1, pk(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 1, pk(0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1, 0, pk(0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1, 1, pk(1, 0, 0, 0, 0, 1)};
        for (int j = 0; j < 8; j++) tbl[4 + j] = '{1, 0, pk(0, 1, bit'(j & 1), j, 0, 1)};
        tbl[12] = '{1, 0, pk(0, 0, 0, 0, 1, 1)};
        tbl[13] = '{1, 0, pk(0, 0, 0, 0, 0, 0)};
        for (int j = 0; j < 14; j++) begin
            tick(tbl[j].r, tbl[j].i);
            chk($sformatf("table[%0d]", j), 16'(v8), 16'(tbl[j].exp));
        end

        // NUM_TERMS=4: err_vld five cycles after the clear cycle
        tick(1, 1);
        cnt4 = -1;
        for (int j = 1; j < 12; j++) begin
            tick(1, 0);
            if (err4 && cnt4 < 0) cnt4 = j;
        end
        chk("nt4_err_latency", 16'(cnt4), 16'd5);

        // Integrated datapath cases
        R[0] = 12'h100;
        run_dp("dp_r0", 16'h0100);
        for (int j = 0; j < 4; j++) begin R[j] = 12'hFFF; L[j] = 12'hFFF; end
        run_dp("dp_all", 16'h0000);
        for (int j = 0; j < 4; j++) begin R[j] = '0; L[j] = '0; end
        L[3] = 12'hFFF;
        run_dp("dp_l3", 16'h8008);

        // Requests at n, n+4 (buffered) and n+6 (dropped)
        errs.delete();
        for (int j = 0; j < 26; j++) begin
            tick(1, (j == 0 || j == 4 || j == 6));
            if (err8) errs.push_back(j);
            if (j == 10) chk("pend_clr", 16'(clr8), 16'h1);
        end
        chk("pend_count", 16'(errs.size()), 16'd2);
        if (errs.size() == 2) begin
            chk("pend_err1", 16'(errs[0]), 16'd9);
            chk("pend_err2", 16'(errs[1]), 16'd19);
        end

        // Reset in the middle of accumulation aborts without err_vld
        tick(1, 1);
        for (int j = 1; j < 5; j++) tick(1, 0);
        tick(0, 0);
        chk("abort_en", 16'({en8, busy8}), 16'h0);
        saw_en = 0;
        for (int j = 0; j < 12; j++) begin
            tick(1, 0);
            if (err8 || en8) saw_en = 1;
        end
        chk("abort_quiet", 16'(saw_en), 16'h0);
        tick(1, 1);
        chk("abort_restart", 16'(clr8), 16'h1);
        idle_out(12);

        // Random traffic with occasional resets
        for (int j = 0; j < 3000; j++) begin
            s = int'($urandom_range(0, 99));
            tick(s != 0, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_err_compute_sm
